// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT input feeder.
package fft_pkg;

   localparam int unsigned STREAM_W = 24;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCapture = 2'd1,
      StDrain   = 2'd2
   } feed_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data; writes while full are dropped.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic             do_wr, do_rd;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         rd_data  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (do_rd) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
            rd_data  <= mem[rd_ptr_q[AW-1:0]];
         end
      end
   end

endmodule

// File: rtl/fft_data_feed.sv
// Captures one frame of offset-binary ADC samples per arm and streams them as
// signed complex beats to an FFT sink with valid/ready handshake.
module fft_data_feed
   import fft_pkg::*;
#(
   parameter int unsigned FRAME_LEN  = 1024,
   parameter int unsigned ADC_W      = 12,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADC_W-1:0]    adc_data,
   input  logic                adc_valid,
   input  logic                frame_arm,
   input  logic                sink_ready,
   output logic [STREAM_W-1:0] sink_real,
   output logic [STREAM_W-1:0] sink_imag,
   output logic                sink_valid,
   output logic                sink_sop,
   output logic                sink_eop,
   output logic                busy,
   output logic                overflow
);

   localparam int unsigned CW = $clog2(FRAME_LEN) + 1;
   localparam logic [CW-1:0] LAST    = CW'(FRAME_LEN - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   feed_state_e         state_q, state_d;
   logic [CW-1:0]       acc_cnt_q, acc_cnt_d, emit_cnt_q, emit_cnt_d;
   logic                overflow_q, overflow_d;
   logic                fifo_wr, fifo_rd, fifo_full, fifo_empty;
   logic [ADC_W-1:0]    fifo_rdata;
   logic                s1_valid_q, s1_valid_d;
   logic                load_out, beat;
   logic [ADC_W-1:0]    conv;
   logic [STREAM_W-1:0] real_d, real_q;
   logic                out_valid_q, sop_q, eop_q;

   sync_fifo #(
      .WIDTH (ADC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (fifo_wr),
      .wr_data (adc_data),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Two-stage read path: FIFO read register (s1) then output register.
   assign load_out   = s1_valid_q && (!out_valid_q || sink_ready);
   assign beat       = out_valid_q && sink_ready;
   assign fifo_rd    = !fifo_empty && (!s1_valid_q || load_out);
   assign s1_valid_d = fifo_rd || (s1_valid_q && !load_out);

   assign conv   = {~fifo_rdata[ADC_W-1], fifo_rdata[ADC_W-2:0]};
   assign real_d = {{(STREAM_W - ADC_W){conv[ADC_W-1]}}, conv};

   always_comb begin
      state_d    = state_q;
      acc_cnt_d  = acc_cnt_q;
      emit_cnt_d = emit_cnt_q;
      overflow_d = overflow_q;
      fifo_wr    = 1'b0;
      if (load_out) begin
         emit_cnt_d = emit_cnt_q + CNT_ONE;
      end
      unique case (state_q)
         StIdle: begin
            if (frame_arm) begin
               state_d    = StCapture;
               acc_cnt_d  = '0;
               emit_cnt_d = '0;
               overflow_d = 1'b0;
            end
         end
         StCapture: begin
            if (adc_valid) begin
               if (fifo_full) begin
                  overflow_d = 1'b1;
               end else begin
                  fifo_wr   = 1'b1;
                  acc_cnt_d = acc_cnt_q + CNT_ONE;
                  if (acc_cnt_q == LAST) begin
                     state_d = StDrain;
                  end
               end
            end
         end
         StDrain: begin
            if (beat && eop_q) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         acc_cnt_q   <= '0;
         emit_cnt_q  <= '0;
         overflow_q  <= 1'b0;
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
         real_q      <= '0;
      end else begin
         state_q    <= state_d;
         acc_cnt_q  <= acc_cnt_d;
         emit_cnt_q <= emit_cnt_d;
         overflow_q <= overflow_d;
         s1_valid_q <= s1_valid_d;
         if (load_out) begin
            out_valid_q <= 1'b1;
            sop_q       <= (emit_cnt_q == '0);
            eop_q       <= (emit_cnt_q == LAST);
            real_q      <= real_d;
         end else if (beat) begin
            out_valid_q <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
         end
      end
   end

   assign sink_real  = real_q;
   assign sink_imag  = '0;
   assign sink_valid = out_valid_q;
   assign sink_sop   = sop_q;
   assign sink_eop   = eop_q;
   assign busy       = (state_q != StIdle);
   assign overflow   = overflow_q;

endmodule
